// File: rtl/ace_snoop_arbiter.sv
// Round-robin arbiter sharing one ACE snoop port among NoSlv initiators; CR/CD are routed back in snoop order.
// Optional occupancy outputs outstanding_o / cd_pending_o are enabled by defining ACE_SNOOP_ARB_CNT_EN.
module ace_snoop_arbiter #(
  parameter int unsigned NoSlv    = 2,
  parameter int unsigned MaxTrans = 4,
  parameter type ac_chan_t = struct packed {
    logic [31:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  },
  parameter type cr_chan_t = logic [4:0],
  parameter type cd_chan_t = struct packed {
    logic [31:0] data;
    logic        last;
  },
  parameter type snoop_req_t = struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  },
  parameter type snoop_resp_t = struct packed {
    logic     ac_ready;
    logic     cr_valid;
    cr_chan_t cr_resp;
    logic     cd_valid;
    cd_chan_t cd;
  }
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  snoop_req_t  [NoSlv-1:0]  slv_reqs_i,
  output snoop_resp_t [NoSlv-1:0]  slv_resps_o,
  output snoop_req_t               mst_req_o,
  input  snoop_resp_t              mst_resp_i
`ifdef ACE_SNOOP_ARB_CNT_EN
  ,
  output logic [$clog2(MaxTrans+1)-1:0] outstanding_o,
  output logic [$clog2(MaxTrans+1)-1:0] cd_pending_o
`endif
);

  localparam int unsigned IdxW = (NoSlv > 1) ? $clog2(NoSlv) : 1;
  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(MaxTrans - 1)) ? '0 : ptr_t'(p + 1'b1);
  endfunction

  // Arbitration state
  idx_t rr_q, rr_d;
  logic lock_q, lock_d;
  idx_t lock_idx_q, lock_idx_d;

  // cr_fifo holds the initiator of every snoop still waiting for CR
  idx_t cr_mem_q [MaxTrans];
  ptr_t cr_wr_q, cr_wr_d, cr_rd_q, cr_rd_d;
  cnt_t cr_cnt_q, cr_cnt_d;

  // cd_fifo holds initiators whose CR announced a data transfer
  idx_t cd_mem_q [MaxTrans];
  ptr_t cd_wr_q, cd_wr_d, cd_rd_q, cd_rd_d;
  cnt_t cd_cnt_q, cd_cnt_d;

  logic cr_full, cr_empty, cd_empty;
  idx_t cr_head, cd_head;

  logic req_found;
  idx_t arb_idx, grant_idx;
  logic grant_req, grant_vld;
  logic ac_hs, cr_hs, cd_hs, cd_push, cd_pop;

  ac_chan_t ac_fwd;
  cr_chan_t cr_fwd;
  cd_chan_t cd_fwd;

  assign cr_full  = (cr_cnt_q == cnt_t'(MaxTrans));
  assign cr_empty = (cr_cnt_q == '0);
  assign cd_empty = (cd_cnt_q == '0);
  assign cr_head  = cr_mem_q[cr_rd_q];
  assign cd_head  = cd_mem_q[cd_rd_q];

  always_comb begin
    idx_t cand;
    cand      = '0;
    req_found = 1'b0;
    arb_idx   = rr_q;
    for (int unsigned i = 0; i < NoSlv; i++) begin
      cand = idx_t'((32'(rr_q) + i) % NoSlv);
      if (!req_found && slv_reqs_i[cand].ac_valid) begin
        req_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // A stalled grant stays put so the downstream AC payload never changes before ready
  assign grant_idx = lock_q ? lock_idx_q : arb_idx;
  assign grant_req = lock_q ? slv_reqs_i[lock_idx_q].ac_valid : req_found;
  assign grant_vld = grant_req & ~cr_full;

  assign ac_hs   = grant_vld & mst_resp_i.ac_ready;
  assign cr_hs   = ~cr_empty & mst_resp_i.cr_valid & slv_reqs_i[cr_head].cr_ready;
  assign cd_push = cr_hs & mst_resp_i.cr_resp[0];
  assign cd_hs   = ~cd_empty & mst_resp_i.cd_valid & slv_reqs_i[cd_head].cd_ready;
  assign cd_pop  = cd_hs & mst_resp_i.cd.last;

  assign ac_fwd = grant_vld ? slv_reqs_i[grant_idx].ac : '0;
  assign cr_fwd = mst_resp_i.cr_valid ? mst_resp_i.cr_resp : '0;
  assign cd_fwd = mst_resp_i.cd_valid ? mst_resp_i.cd : '0;

  always_comb begin
    slv_resps_o = '0;
    mst_req_o   = '0;
    if (grant_vld) begin
      mst_req_o.ac_valid                = 1'b1;
      mst_req_o.ac                      = ac_fwd;
      slv_resps_o[grant_idx].ac_ready   = mst_resp_i.ac_ready;
    end
    if (!cr_empty) begin
      slv_resps_o[cr_head].cr_valid     = mst_resp_i.cr_valid;
      slv_resps_o[cr_head].cr_resp      = cr_fwd;
      mst_req_o.cr_ready                = slv_reqs_i[cr_head].cr_ready;
    end
    if (!cd_empty) begin
      slv_resps_o[cd_head].cd_valid     = mst_resp_i.cd_valid;
      slv_resps_o[cd_head].cd           = cd_fwd;
      mst_req_o.cd_ready                = slv_reqs_i[cd_head].cd_ready;
    end
  end

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (ac_hs) begin
      lock_d = 1'b0;
      rr_d   = (grant_idx == idx_t'(NoSlv - 1)) ? '0 : idx_t'(grant_idx + 1'b1);
    end else if (grant_vld) begin
      lock_d     = 1'b1;
      lock_idx_d = grant_idx;
    end
  end

  always_comb begin
    cr_wr_d  = ac_hs   ? ptr_inc(cr_wr_q) : cr_wr_q;
    cr_rd_d  = cr_hs   ? ptr_inc(cr_rd_q) : cr_rd_q;
    cr_cnt_d = cnt_t'(cr_cnt_q + cnt_t'(ac_hs) - cnt_t'(cr_hs));
    cd_wr_d  = cd_push ? ptr_inc(cd_wr_q) : cd_wr_q;
    cd_rd_d  = cd_pop  ? ptr_inc(cd_rd_q) : cd_rd_q;
    cd_cnt_d = cnt_t'(cd_cnt_q + cnt_t'(cd_push) - cnt_t'(cd_pop));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      cr_wr_q    <= '0;
      cr_rd_q    <= '0;
      cr_cnt_q   <= '0;
      cd_wr_q    <= '0;
      cd_rd_q    <= '0;
      cd_cnt_q   <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      cr_wr_q    <= cr_wr_d;
      cr_rd_q    <= cr_rd_d;
      cr_cnt_q   <= cr_cnt_d;
      cd_wr_q    <= cd_wr_d;
      cd_rd_q    <= cd_rd_d;
      cd_cnt_q   <= cd_cnt_d;
    end
  end

  // Storage needs no reset: occupancy counters gate every read
  always_ff @(posedge clk_i) begin
    if (ac_hs)   cr_mem_q[cr_wr_q] <= grant_idx;
    if (cd_push) cd_mem_q[cd_wr_q] <= cr_head;
  end

`ifdef ACE_SNOOP_ARB_CNT_EN
  assign outstanding_o = cr_cnt_q;
  assign cd_pending_o  = cd_cnt_q;
`endif

  cr_without_snoop: assert property (@(posedge clk_i) disable iff (rst_i)
    mst_resp_i.cr_valid |-> !cr_empty);

  cd_fifo_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    cd_push |-> (cd_cnt_q != cnt_t'(MaxTrans)) || cd_pop);

endmodule

// File: tb/tb_ace_snoop_arbiter.sv
// Directed bench for ace_snoop_arbiter: RR grants, AC lock, full stall, CR/CD routing, reset.
module tb_ace_snoop_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } ac_t;
  typedef logic [4:0] cr_t;
  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } cd_t;
  typedef struct packed {
    logic ac_valid;
    ac_t  ac;
    logic cr_ready;
    logic cd_ready;
  } req_t;
  typedef struct packed {
    logic ac_ready;
    logic cr_valid;
    cr_t  cr_resp;
    logic cd_valid;
    cd_t  cd;
  } resp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  req_t  [1:0] slv_reqs;
  resp_t [1:0] slv_resps;
  req_t        mst_req;
  resp_t       mst_resp;
`ifdef ACE_SNOOP_ARB_CNT_EN
  logic [2:0] outstanding, cd_pending;
`endif

  int errors = 0;
  int checks = 0;

  ace_snoop_arbiter #(
    .NoSlv(2), .MaxTrans(4),
    .ac_chan_t(ac_t), .cr_chan_t(cr_t), .cd_chan_t(cd_t),
    .snoop_req_t(req_t), .snoop_resp_t(resp_t)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .slv_reqs_i(slv_reqs),
    .slv_resps_o(slv_resps),
    .mst_req_o(mst_req),
    .mst_resp_i(mst_resp)
`ifdef ACE_SNOOP_ARB_CNT_EN
    ,
    .outstanding_o(outstanding),
    .cd_pending_o(cd_pending)
`endif
  );

  task automatic clear_inputs();
    slv_reqs = '0;
    mst_resp = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({mst_req, slv_resps} !== '0)
      begin errors++; $display("FAIL reset_outputs: got mst=%h slv=%h want 0", mst_req, slv_resps); end
`ifdef ACE_SNOOP_ARB_CNT_EN
    checks++;
    if ({outstanding, cd_pending} !== 6'd0)
      begin errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", outstanding, cd_pending); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_alternate();
    int g, c;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      slv_reqs[0].ac_valid = (i < 4);
      slv_reqs[1].ac_valid = (i < 4);
      slv_reqs[0].ac.addr  = 32'h100;
      slv_reqs[1].ac.addr  = 32'h200;
      slv_reqs[0].cr_ready = 1'b1;
      slv_reqs[1].cr_ready = 1'b1;
      mst_resp.ac_ready    = 1'b1;
      mst_resp.cr_valid    = (i > 0);
      mst_resp.cr_resp     = cr_t'(2 * i + 2);
      #1;
      if (i < 4) begin
        g = i % 2;
        checks++;
        if ({mst_req.ac_valid, mst_req.ac.addr, slv_resps[1].ac_ready, slv_resps[0].ac_ready} !==
            {1'b1, (g == 1) ? 32'h200 : 32'h100, g == 1, g == 0})
          begin errors++; $display("FAIL alt_grant cyc%0d: got addr=%h rdy=%b%b want port %0d", i, mst_req.ac.addr, slv_resps[1].ac_ready, slv_resps[0].ac_ready, g); end
      end
      if (i > 0) begin
        c = (i - 1) % 2;
        checks++;
        if ({slv_resps[1].cr_valid, slv_resps[0].cr_valid, slv_resps[c].cr_resp} !==
            {c == 1, c == 0, cr_t'(2 * i + 2)})
          begin errors++; $display("FAIL alt_cr cyc%0d: got vld=%b%b resp=%h want port %0d", i, slv_resps[1].cr_valid, slv_resps[0].cr_valid, slv_resps[c].cr_resp, c); end
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_lock();
    int exp_p[3] = '{0, 0, 1};
    @(negedge clk);
    slv_reqs[0].ac_valid = 1'b1;
    slv_reqs[0].ac.addr  = 32'h2F0;
    mst_resp.ac_ready    = 1'b1;
    #1;
    checks++;
    if ({mst_req.ac_valid, mst_req.ac.addr} !== {1'b1, 32'h2F0})
      begin errors++; $display("FAIL lock_pre: got %b %h want 1 2f0", mst_req.ac_valid, mst_req.ac.addr); end
    @(negedge clk);
    slv_reqs[0].ac.addr = 32'h300;
    mst_resp.ac_ready   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(negedge clk);
        slv_reqs[1].ac_valid = 1'b1;
        slv_reqs[1].ac.addr  = 32'h310;
      end
      #1;
      checks++;
      if ({mst_req.ac_valid, mst_req.ac.addr, slv_resps[0].ac_ready, slv_resps[1].ac_ready} !== {1'b1, 32'h300, 2'b00})
        begin errors++; $display("FAIL lock_hold cyc%0d: got %b %h %b%b want 1 300 00", k, mst_req.ac_valid, mst_req.ac.addr, slv_resps[0].ac_ready, slv_resps[1].ac_ready); end
    end
    @(negedge clk);
    mst_resp.ac_ready = 1'b1;
    #1;
    checks++;
    if ({mst_req.ac.addr, slv_resps[0].ac_ready, slv_resps[1].ac_ready} !== {32'h300, 2'b10})
      begin errors++; $display("FAIL lock_release: got %h %b%b want 300 10", mst_req.ac.addr, slv_resps[0].ac_ready, slv_resps[1].ac_ready); end
    @(negedge clk);
    slv_reqs[0].ac_valid = 1'b0;
    #1;
    checks++;
    if ({mst_req.ac_valid, mst_req.ac.addr, slv_resps[0].ac_ready, slv_resps[1].ac_ready} !== {1'b1, 32'h310, 2'b01})
      begin errors++; $display("FAIL lock_next: got %b %h %b%b want 1 310 01", mst_req.ac_valid, mst_req.ac.addr, slv_resps[0].ac_ready, slv_resps[1].ac_ready); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      slv_reqs[1].ac_valid = 1'b0;
      mst_resp.ac_ready    = 1'b0;
      slv_reqs[0].cr_ready = 1'b1;
      slv_reqs[1].cr_ready = 1'b1;
      mst_resp.cr_valid    = 1'b1;
      #1;
      checks++;
      if ({slv_resps[1].cr_valid, slv_resps[0].cr_valid} !== {exp_p[j] == 1, exp_p[j] == 0})
        begin errors++; $display("FAIL lock_cr%0d: got %b%b want port %0d", j, slv_resps[1].cr_valid, slv_resps[0].cr_valid, exp_p[j]); end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      slv_reqs[0].ac_valid = 1'b1;
      slv_reqs[1].ac_valid = 1'b1;
      slv_reqs[0].ac.addr  = 32'h400;
      slv_reqs[1].ac.addr  = 32'h500;
      mst_resp.ac_ready    = 1'b1;
      #1;
      checks++;
      if (mst_req.ac.addr !== ((i % 2) ? 32'h500 : 32'h400))
        begin errors++; $display("FAIL full_fill%0d: got %h", i, mst_req.ac.addr); end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({mst_req.ac_valid, slv_resps[1].ac_ready, slv_resps[0].ac_ready} !== 3'b000)
      begin errors++; $display("FAIL full_stall: got %b%b%b want 000", mst_req.ac_valid, slv_resps[1].ac_ready, slv_resps[0].ac_ready); end
`ifdef ACE_SNOOP_ARB_CNT_EN
    checks++;
    if (outstanding !== 3'd4)
      begin errors++; $display("FAIL full_count: got %0d want 4", outstanding); end
`endif
    @(negedge clk);
    slv_reqs[0].cr_ready = 1'b1;
    slv_reqs[1].cr_ready = 1'b1;
    mst_resp.cr_valid    = 1'b1;
    #1;
    checks++;
    if ({mst_req.ac_valid, slv_resps[0].cr_valid} !== 2'b01)
      begin errors++; $display("FAIL full_same_cycle: got ac_valid=%b cr0=%b want 0 1", mst_req.ac_valid, slv_resps[0].cr_valid); end
    @(negedge clk);
    mst_resp.cr_valid = 1'b0;
    #1;
    checks++;
    if ({mst_req.ac_valid, mst_req.ac.addr, slv_resps[0].ac_ready} !== {1'b1, 32'h400, 1'b1})
      begin errors++; $display("FAIL full_regrant: got %b %h %b want 1 400 1", mst_req.ac_valid, mst_req.ac.addr, slv_resps[0].ac_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      slv_reqs[0].ac_valid = 1'b0;
      slv_reqs[1].ac_valid = 1'b0;
      mst_resp.cr_valid    = 1'b1;
      #1;
      checks++;
      if ({slv_resps[1].cr_valid, slv_resps[0].cr_valid} !== ((i % 2) ? 2'b01 : 2'b10))
        begin errors++; $display("FAIL full_drain%0d: got %b%b", i, slv_resps[1].cr_valid, slv_resps[0].cr_valid); end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_cd_burst();
    logic [31:0] beat_data[4] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
    int   beat_idx[5] = '{0, 1, 1, 2, 3};
    logic beat_rdy[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int   b;
    @(negedge clk);
    slv_reqs[1].ac_valid = 1'b1;
    slv_reqs[1].ac.addr  = 32'h600;
    slv_reqs[0].cr_ready = 1'b1;
    slv_reqs[1].cr_ready = 1'b1;
    slv_reqs[0].cd_ready = 1'b1;
    mst_resp.ac_ready    = 1'b1;
    #1;
    checks++;
    if ({mst_req.ac.addr, slv_resps[1].ac_ready} !== {32'h600, 1'b1})
      begin errors++; $display("FAIL cd_snoop: got %h %b want 600 1", mst_req.ac.addr, slv_resps[1].ac_ready); end
    @(negedge clk);
    slv_reqs[1].ac_valid = 1'b0;
    mst_resp.cr_valid    = 1'b1;
    mst_resp.cr_resp     = 5'h01;
    #1;
    checks++;
    if ({slv_resps[1].cr_valid, slv_resps[1].cr_resp, slv_resps[0].cr_valid} !== {1'b1, 5'h01, 1'b0})
      begin errors++; $display("FAIL cd_cr: got %b %h %b want 1 01 0", slv_resps[1].cr_valid, slv_resps[1].cr_resp, slv_resps[0].cr_valid); end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      b = beat_idx[s];
      mst_resp.cr_valid     = 1'b0;
      mst_resp.cd_valid     = 1'b1;
      mst_resp.cd.data      = beat_data[b];
      mst_resp.cd.last      = (b == 3);
      slv_reqs[1].cd_ready  = beat_rdy[s];
      #1;
      checks++;
      if ({slv_resps[1].cd_valid, slv_resps[1].cd.data, slv_resps[1].cd.last, slv_resps[0].cd_valid, mst_req.cd_ready} !==
          {1'b1, beat_data[b], b == 3, 1'b0, beat_rdy[s]})
        begin errors++; $display("FAIL cd_beat%0d: got v1=%b d=%h l=%b v0=%b rdy=%b want d=%h rdy=%b", s, slv_resps[1].cd_valid, slv_resps[1].cd.data, slv_resps[1].cd.last, slv_resps[0].cd_valid, mst_req.cd_ready, beat_data[b], beat_rdy[s]); end
    end
    @(negedge clk);
    mst_resp.cd_valid    = 1'b0;
    slv_reqs[1].cd_ready = 1'b1;
    #1;
    checks++;
    if (mst_req.cd_ready !== 1'b0)
      begin errors++; $display("FAIL cd_empty: got cd_ready=%b want 0", mst_req.cd_ready); end
`ifdef ACE_SNOOP_ARB_CNT_EN
    checks++;
    if ({outstanding, cd_pending} !== 6'd0)
      begin errors++; $display("FAIL cd_counts: got %0d/%0d want 0/0", outstanding, cd_pending); end
`endif
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_cd_before_cr();
    @(negedge clk);
    slv_reqs[0].ac_valid = 1'b1;
    slv_reqs[0].ac.addr  = 32'h700;
    slv_reqs[0].cr_ready = 1'b1;
    slv_reqs[0].cd_ready = 1'b1;
    mst_resp.ac_ready    = 1'b1;
    #1;
    checks++;
    if ({mst_req.ac.addr, slv_resps[0].ac_ready} !== {32'h700, 1'b1})
      begin errors++; $display("FAIL early_snoop: got %h %b want 700 1", mst_req.ac.addr, slv_resps[0].ac_ready); end
    @(negedge clk);
    slv_reqs[0].ac_valid = 1'b0;
    mst_resp.cd_valid    = 1'b1;
    mst_resp.cd.data     = 32'hCAFE_F00D;
    mst_resp.cd.last     = 1'b1;
    #1;
    checks++;
    if ({mst_req.cd_ready, slv_resps[0].cd_valid} !== 2'b00)
      begin errors++; $display("FAIL early_hold: got rdy=%b v=%b want 0 0", mst_req.cd_ready, slv_resps[0].cd_valid); end
    @(negedge clk);
    mst_resp.cr_valid = 1'b1;
    mst_resp.cr_resp  = 5'h01;
    #1;
    checks++;
    if ({mst_req.cd_ready, slv_resps[0].cd_valid, slv_resps[0].cr_valid} !== 3'b001)
      begin errors++; $display("FAIL early_no_bypass: got %b%b%b want 001", mst_req.cd_ready, slv_resps[0].cd_valid, slv_resps[0].cr_valid); end
    @(negedge clk);
    mst_resp.cr_valid = 1'b0;
    #1;
    checks++;
    if ({mst_req.cd_ready, slv_resps[0].cd_valid, slv_resps[0].cd.data, slv_resps[0].cd.last} !== {2'b11, 32'hCAFE_F00D, 1'b1})
      begin errors++; $display("FAIL early_deliver: got %b%b %h %b want 11 cafef00d 1", mst_req.cd_ready, slv_resps[0].cd_valid, slv_resps[0].cd.data, slv_resps[0].cd.last); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    slv_reqs[0].ac_valid = 1'b1;
    slv_reqs[1].ac_valid = 1'b1;
    slv_reqs[0].ac.addr  = 32'h800;
    slv_reqs[1].ac.addr  = 32'h900;
    mst_resp.ac_ready    = 1'b1;
    #1;
    checks++;
    if (mst_req.ac.addr !== 32'h900)
      begin errors++; $display("FAIL rst_pre1: got %h want 900", mst_req.ac.addr); end
    @(negedge clk);
    #1;
    checks++;
    if (mst_req.ac.addr !== 32'h800)
      begin errors++; $display("FAIL rst_pre2: got %h want 800", mst_req.ac.addr); end
    @(negedge clk);
    slv_reqs[0].ac_valid = 1'b0;
    slv_reqs[1].ac_valid = 1'b0;
    slv_reqs[0].cr_ready = 1'b1;
    slv_reqs[1].cr_ready = 1'b1;
    slv_reqs[0].cd_ready = 1'b1;
    slv_reqs[1].cd_ready = 1'b1;
    #1;
    checks++;
    if (mst_req.cr_ready !== 1'b1)
      begin errors++; $display("FAIL rst_pending: got cr_ready=%b want 1", mst_req.cr_ready); end
`ifdef ACE_SNOOP_ARB_CNT_EN
    checks++;
    if (outstanding !== 3'd2)
      begin errors++; $display("FAIL rst_pending_cnt: got %0d want 2", outstanding); end
`endif
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({mst_req, slv_resps} !== '0)
      begin errors++; $display("FAIL rst_mid_outputs: got mst=%h slv=%h want 0", mst_req, slv_resps); end
`ifdef ACE_SNOOP_ARB_CNT_EN
    checks++;
    if (outstanding !== 3'd0)
      begin errors++; $display("FAIL rst_mid_cnt: got %0d want 0", outstanding); end
`endif
    rst = 1'b0;
    @(negedge clk);
    slv_reqs[0].ac_valid = 1'b1;
    slv_reqs[1].ac_valid = 1'b1;
    #1;
    checks++;
    if ({mst_req.ac_valid, mst_req.ac.addr, slv_resps[0].ac_ready} !== {1'b1, 32'h800, 1'b1})
      begin errors++; $display("FAIL rst_fresh: got %b %h %b want 1 800 1", mst_req.ac_valid, mst_req.ac.addr, slv_resps[0].ac_ready); end
    @(negedge clk);
    slv_reqs[0].ac_valid = 1'b0;
    slv_reqs[1].ac_valid = 1'b0;
    mst_resp.cr_valid    = 1'b1;
    mst_resp.cr_resp     = 5'h04;
    #1;
    checks++;
    if ({slv_resps[0].cr_valid, slv_resps[1].cr_valid, slv_resps[0].cr_resp, mst_req.cr_ready} !== {2'b10, 5'h04, 1'b1})
      begin errors++; $display("FAIL rst_fresh_cr: got %b%b %h %b want 10 04 1", slv_resps[0].cr_valid, slv_resps[1].cr_valid, slv_resps[0].cr_resp, mst_req.cr_ready); end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_alternate();
    test_lock();
    test_full();
    test_cd_burst();
    test_cd_before_cr();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
